// File: rtl/pipe_stream_arbiter.sv
// Round-robin merge of NUM_REQ pipelined FIFO streams into one registered
// output stream. A requester that wins keeps the grant for up to MAX_BURST
// consecutive words. Each output word is tagged with the index of its source.
module pipe_stream_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 4,
    localparam int SRC_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            reset_poweron,
    input  logic                            clear,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_read,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [SRC_WIDTH-1:0]            out_src
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCKED} mode_e;

    mode_e                  mode_q, mode_d;
    logic [SRC_WIDTH-1:0]   owner_q, owner_d;
    logic [SRC_WIDTH-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_inc;

    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic [SRC_WIDTH-1:0]   out_src_q;

    logic                   owner_hold;
    logic                   found;
    logic                   opp;
    logic                   flush;
    logic                   load;
    logic [SRC_WIDTH-1:0]   search_start;
    logic [SRC_WIDTH-1:0]   grant;
    logic [SRC_WIDTH-1:0]   idx;
    logic [DATA_WIDTH-1:0]  grant_data;

    // Index increment that wraps at NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [SRC_WIDTH-1:0] wrap_inc(input logic [SRC_WIDTH-1:0] v);
        if (v == SRC_WIDTH'(NUM_REQ - 1)) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    assign opp   = ~out_valid_q | out_ready;
    assign flush = reset_poweron | clear;
    assign load  = opp & found & ~flush;

    // Grant: keep the lock owner while it is valid, otherwise search round-robin.
    // A dropped owner is replaced in the same cycle by searching from owner+1.
    always_comb begin
        owner_hold   = (mode_q == LOCKED) && req_valid[owner_q];
        search_start = (mode_q == LOCKED) ? wrap_inc(owner_q) : rr_q;
        found        = owner_hold;
        grant        = owner_q;
        idx          = search_start;
        if (!owner_hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    grant = idx;
                end
                idx = wrap_inc(idx);
            end
        end
    end

    // Data mux for the granted stream.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == SRC_WIDTH'(i)) begin
                grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // One-hot consume pulse, only in a load cycle.
    always_comb begin
        req_read = '0;
        if (load) begin
            req_read[grant] = 1'b1;
        end
    end

    // Next arbitration state; everything holds while the output is back-pressured.
    always_comb begin
        mode_d  = mode_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 1'b1;
        if (opp) begin
            if (owner_hold) begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(MAX_BURST)) begin
                    mode_d = IDLE;
                    rr_d   = wrap_inc(owner_q);
                end
            end else begin
                if (mode_q == LOCKED) begin
                    mode_d = IDLE;
                    rr_d   = wrap_inc(owner_q);
                end
                if (found) begin
                    if (MAX_BURST > 1) begin
                        mode_d  = LOCKED;
                        owner_d = grant;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        rr_d = wrap_inc(grant);
                    end
                end
            end
        end
    end

    // Arbitration state register; reset and clear act identically here.
    always_ff @(posedge clk) begin
        if (flush) begin
            mode_q  <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output register; clear drops the word but keeps data/src for inspection.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else if (clear) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= grant_data;
            out_src_q   <= grant;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_pipe_stream_arbiter.sv
// Bench for pipe_stream_arbiter: two instances (MAX_BURST=4 and MAX_BURST=1)
// fed by FIFO-like stream drivers, checked every cycle against a behavioural
// model plus a per-stream ordering scoreboard and literal sequence checks.
module tb_pipe_stream_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int SW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst  [2];
    logic             clr  [2];
    logic             ordy [2];
    logic [N-1:0]     rv   [2];
    logic [N-1:0]     rread[2];
    logic [N*W-1:0]   rdat [2];
    logic             ov   [2];
    logic [W-1:0]     od   [2];
    logic [SW-1:0]    os   [2];

    pipe_stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(4)) u_dut0 (
        .clk(clk), .reset_poweron(rst[0]), .clear(clr[0]),
        .req_valid(rv[0]), .req_data(rdat[0]), .req_read(rread[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_src(os[0])
    );

    pipe_stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .reset_poweron(rst[1]), .clear(clr[1]),
        .req_valid(rv[1]), .req_data(rdat[1]), .req_read(rread[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_src(os[1])
    );

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;
    int cyc_no = 0;

    int           seq     [2][N];
    int           sb_next [2][N];
    logic [N-1:0] rd_seen [2];
    int           vmode   [2];
    int           rmode   [2];
    int           s1cnt;

    int acc_src0[$];
    int acc_cyc0[$];
    int acc_src1[$];

    // Model: grant continues the current run while it is shorter than the burst
    // limit and the owner is still valid; otherwise first valid stream found
    // scanning from one past the last grantee (0 after reset/clear).
    int           m_ptr [2];
    int           m_run [2];
    int           m_own [2];
    logic         m_ov  [2];
    logic [W-1:0] m_od  [2];
    int           m_os  [2];

    function automatic int burst_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    function automatic logic [W-1:0] word(input int i, input int s);
        logic [W-1:0] r;
        r        = W'(s) & 32'h00FF_FFFF;
        r[31:24] = i[7:0];
        return r;
    endfunction

    task automatic check(input string name, input int u, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc%0d: got %0h, expected %0h", name, u, cyc_no, act, exp);
        end
    endtask

    task automatic apply();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < N; i++) begin
                case (vmode[u])
                    0:       rv[u][i] = ($urandom_range(3) != 0);
                    1:       rv[u][i] = 1'b1;
                    2:       rv[u][i] = (i == 3) || (i == 1 && s1cnt < 2);
                    3:       rv[u][i] = (i == 0) || (i == 2);
                    default: rv[u][i] = (i == 2);
                endcase
                rdat[u][i*W +: W] = word(i, seq[u][i]);
            end
            case (rmode[u])
                0:       ordy[u] = 1'b1;
                1:       ordy[u] = ($urandom_range(1) == 1);
                default: ordy[u] = 1'b0;
            endcase
        end
    endtask

    task automatic advance();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < N; i++) begin
                if (rd_seen[u][i]) begin
                    seq[u][i]++;
                    if (u == 0 && i == 1) s1cnt++;
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            advance();
            apply();
        end
    endtask

    task automatic model_cycle(input int u);
        logic [N-1:0] v;
        logic [N-1:0] er;
        bit found, cont, opp, load;
        int g, s;
        v = rv[u];
        found = 1'b0; cont = 1'b0; g = 0;
        if (m_run[u] > 0 && v[m_own[u]]) begin
            found = 1'b1; cont = 1'b1; g = m_own[u];
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!found && v[(m_ptr[u] + k) % N]) begin
                    found = 1'b1;
                    g = (m_ptr[u] + k) % N;
                end
            end
        end
        opp  = !m_ov[u] || ordy[u];
        load = opp && found && !rst[u] && !clr[u];
        er = '0;
        if (load) er[g] = 1'b1;

        if (armed) begin
            check("req_read", u, rread[u], er);
            check("out_valid", u, ov[u], m_ov[u]);
            check("out_data", u, od[u], m_od[u]);
            check("out_src", u, os[u], m_os[u]);
            if (ov[u] && ordy[u]) begin
                s = int'(os[u]);
                check("stream_order", u, od[u], word(s, sb_next[u][s]));
                sb_next[u][s]++;
                if (u == 0) begin
                    acc_src0.push_back(s);
                    acc_cyc0.push_back(cyc_no);
                end else begin
                    acc_src1.push_back(s);
                end
            end
        end
        rd_seen[u] = rread[u];

        if (rst[u] || clr[u]) begin
            if (m_ov[u] && !ordy[u]) sb_next[u][m_os[u]]++;
            m_ptr[u] = 0; m_run[u] = 0; m_own[u] = 0; m_ov[u] = 1'b0;
            if (rst[u]) begin
                m_od[u] = '0;
                m_os[u] = 0;
            end
        end else if (load) begin
            m_run[u] = cont ? m_run[u] + 1 : 1;
            m_own[u] = g;
            m_ptr[u] = (g + 1) % N;
            if (m_run[u] == burst_of(u)) m_run[u] = 0;
            m_ov[u]  = 1'b1;
            m_od[u]  = rdat[u][g*W +: W];
            m_os[u]  = g;
        end else begin
            if (opp && !found) m_run[u] = 0;
            if (ordy[u]) m_ov[u] = 1'b0;
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        cyc_no++;
        model_cycle(0);
        model_cycle(1);
    end

    task automatic reset0();
        rst[0] = 1'b1;
        apply();
        cyc(1);
        rst[0] = 1'b0;
        acc_src0.delete();
        acc_cyc0.delete();
        s1cnt = 0;
        apply();
    endtask

    int exp_rr[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
    int exp_er[6]  = '{1,1,3,3,3,3};

    task automatic check_rr(input string name);
        check({name, "_count"}, 0, acc_src0.size() >= 17, 1);
        if (acc_src0.size() >= 17) begin
            for (int k = 0; k < 17; k++) check(name, 0, acc_src0[k], exp_rr[k]);
        end
    endtask

    initial begin
        logic [W-1:0]  snap_d;
        logic [SW-1:0] snap_s;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; clr[u] = 1'b0; rd_seen[u] = '0;
            m_ptr[u] = 0; m_run[u] = 0; m_own[u] = 0;
            m_ov[u] = 1'b0; m_od[u] = '0; m_os[u] = 0;
            for (int i = 0; i < N; i++) begin
                seq[u][i] = 0;
                sb_next[u][i] = 0;
            end
        end
        s1cnt = 0;
        vmode[0] = 1; vmode[1] = 3;
        rmode[0] = 0; rmode[1] = 1;
        apply();

        // Reset held two cycles with every stream valid.
        @(posedge clk);
        #1;
        armed = 1'b1;
        @(negedge clk);
        check("rst_req_read", 0, rread[0], 0);
        check("rst_out_valid", 0, ov[0], 0);
        check("rst_out_data", 0, od[0], 0);
        cyc(1);
        @(negedge clk);
        check("rst_req_read2", 0, rread[0], 0);
        check("rst_out_valid2", 0, ov[0], 0);
        check("rst_out_src2", 0, os[0], 0);
        cyc(1);
        rst[0] = 1'b0; rst[1] = 1'b0;
        acc_src0.delete(); acc_cyc0.delete(); acc_src1.delete();
        apply();

        // Full contention, bursts of four in round-robin order.
        cyc(20);
        check_rr("contention_src");

        // Back-pressure for five cycles in the middle of the first burst.
        reset0();
        cyc(3);
        rmode[0] = 2;
        apply();
        @(negedge clk);
        snap_d = od[0];
        snap_s = os[0];
        check("bp_valid", 0, ov[0], 1);
        check("bp_read", 0, rread[0], 0);
        repeat (4) begin
            cyc(1);
            @(negedge clk);
            check("bp_read", 0, rread[0], 0);
            check("bp_data_stable", 0, od[0], snap_d);
            check("bp_src_stable", 0, os[0], snap_s);
        end
        rmode[0] = 0;
        cyc(1);
        cyc(20);
        check_rr("bp_resume_src");

        // Early lock release: stream 1 gives two words, stream 3 takes over at once.
        vmode[0] = 2;
        reset0();
        cyc(10);
        check("early_count", 0, acc_src0.size() >= 6, 1);
        if (acc_src0.size() >= 6) begin
            for (int k = 0; k < 6; k++) check("early_src", 0, acc_src0[k], exp_er[k]);
            check("early_no_bubble", 0, acc_cyc0[2] - acc_cyc0[1], 1);
        end

        // Clear while locked on stream 2 with two words granted.
        vmode[0] = 4;
        reset0();
        cyc(2);
        clr[0] = 1'b1;
        vmode[0] = 1;
        apply();
        @(negedge clk);
        snap_d = od[0];
        check("clr_read_blocked", 0, rread[0], 0);
        check("clr_owner_src", 0, os[0], 2);
        cyc(1);
        clr[0] = 1'b0;
        apply();
        @(negedge clk);
        check("clr_out_valid", 0, ov[0], 0);
        check("clr_data_kept", 0, od[0], snap_d);
        check("clr_next_grant", 0, rread[0], 4'b0001);

        // MAX_BURST=1 instance has been alternating streams 0 and 2 under random ready.
        check("mb1_count", 1, acc_src1.size() >= 10, 1);
        if (acc_src1.size() >= 10) begin
            for (int k = 0; k < 10; k++) check("mb1_alternate", 1, acc_src1[k], (k % 2 == 0) ? 0 : 2);
        end

        // Random traffic with occasional clear and reset on both instances.
        vmode[0] = 0; vmode[1] = 0;
        rmode[0] = 1; rmode[1] = 1;
        for (int t = 0; t < 800; t++) begin
            cyc(1);
            for (int u = 0; u < 2; u++) begin
                clr[u] = ($urandom_range(39) == 0);
                rst[u] = ($urandom_range(199) == 0);
            end
            apply();
        end
        for (int u = 0; u < 2; u++) begin
            clr[u] = 1'b0;
            rst[u] = 1'b0;
        end
        apply();
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
